// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int PC_W         = 5;
    localparam int INSTR_W      = 16;
    localparam int FQ_DEPTH_DEF = 4;

    // One fetch-queue entry: the instruction word and the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fq_entry_t;

    localparam fq_entry_t FQ_ENTRY_ZERO = '{instr: {INSTR_W{1'b0}}, pc: {PC_W{1'b0}}};

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake: head instruction, its address, valid/ready.
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (output instr, output instr_pc, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_pc, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Fetch queue: power-of-two ring buffer with push, pop, flush, count and head.
// The head reads as all zeros while the queue is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
)(
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  fq_entry_t        i_data,
    output logic [CNT_W-1:0] o_count,
    output fq_entry_t        o_head
);

    fq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;

    assign w_nonempty = (r_count != {CNT_W{1'b0}});
    assign w_pop      = i_pop && w_nonempty;
    // A push into a full queue is refused unless a pop frees a slot this cycle.
    assign w_push     = i_push && (w_pop || (r_count < CNT_W'(DEPTH)));
    assign o_count    = r_count;

    // Storage, pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= FQ_ENTRY_ZERO;
            end
        end else if (i_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry, forced to zero when nothing is queued.
    always_comb begin
        o_head = FQ_ENTRY_ZERO;
        if (w_nonempty) begin
            o_head = r_mem[r_rd_ptr];
        end else begin
            o_head = FQ_ENTRY_ZERO;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives a synchronous 32-word ROM, buffers returned
// words in a fetch queue and hands them to decode over a valid/ready link.
// Optional build macro FETCH_PERF_EN adds saturating transfer/stall counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int FQ_DEPTH = FQ_DEPTH_DEF
)(
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Run,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    instr_fetch_unit_if.master dec
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_infl_pc;
    logic             r_infl;
    logic [CNT_W-1:0] w_count;
    logic [OCC_W-1:0] w_occupancy;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    fq_entry_t        w_head;
    fq_entry_t        w_push_data;

    // Queue slots plus the read still in the ROM; a same-cycle pop is not
    // credited, which keeps the issue decision off the decode ready path.
    assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_infl};
    assign w_issue     = Run && !redirect && (w_occupancy < OCC_W'(FQ_DEPTH));
    assign w_valid     = (w_count != {CNT_W{1'b0}});
    assign w_pop       = w_valid && dec.instr_ready;
    // The ROM word for a read issued before a redirect is stale: drop it.
    assign w_push      = r_infl && !redirect;
    assign w_push_data = '{instr: rom_data, pc: r_infl_pc};

    assign rom_addr        = r_pc;
    assign dec.instr       = w_head.instr;
    assign dec.instr_pc    = w_head.pc;
    assign dec.instr_valid = w_valid;

    // Fetch PC and the one-cycle inflight marker for the ROM read.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_pc      <= {PC_W{1'b0}};
            r_infl    <= 1'b0;
            r_infl_pc <= {PC_W{1'b0}};
        end else if (redirect) begin
            r_pc      <= redirect_pc;
            r_infl    <= 1'b0;
            r_infl_pc <= r_infl_pc;
        end else if (w_issue) begin
            r_pc      <= r_pc + PC_W'(1);
            r_infl    <= 1'b1;
            r_infl_pc <= r_pc;
        end else begin
            r_pc      <= r_pc;
            r_infl    <= 1'b0;
            r_infl_pc <= r_infl_pc;
        end
    end

    fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  (w_push_data),
        .o_count (w_count),
        .o_head  (w_head)
    );

`ifdef FETCH_PERF_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    // Transfer and stall counters; redirects do not touch them.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_fetch_cnt <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (w_pop) begin
                r_fetch_cnt <= sat_inc16(r_fetch_cnt);
            end else begin
                r_fetch_cnt <= r_fetch_cnt;
            end
            if (w_valid && !dec.instr_ready) begin
                r_stall_cnt <= sat_inc16(r_stall_cnt);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
